// File: rtl/c1581_pkg.sv
// Shared types and constants for the 1581 fast-serial host engine.
package c1581_pkg;

    localparam int unsigned FSER_BITS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RX_SHIFT = 2'd1,
        TX_LOW   = 2'd2,
        TX_HIGH  = 2'd3
    } fser_state_t;

endpackage

// File: rtl/c1581_fser_filt.sv
// Two-flop synchronizer with stability filter and edge detection for one
// wired-AND bus line; everything advances only on ce.
module c1581_fser_filt (
    input  logic clk,
    input  logic res_n,
    input  logic ce,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic s1;
    logic s2;
    logic level_d;

    // Released (1) is the idle level, so reset never produces a spurious edge.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
        end else if (ce) begin
            s1      <= pin;
            s2      <= s1;
            if (s1 == s2) begin
                level <= s2;
            end
            level_d <= level;
        end
    end

    assign rise_c = level & ~level_d;
    assign fall_c = ~level & level_d;

endmodule

// File: rtl/c1581_fser_host.sv
// Host-side fast-serial engine: receives drive-clocked bytes on FCLK/DATA and
// transmits host bytes with the host clocking FCLK.
module c1581_fser_host
    import c1581_pkg::*;
#(
    parameter int unsigned TX_HALF = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ce,
    input  logic       fclk_i,
    input  logic       data_i,
    output logic       fclk_o,
    output logic       data_o,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       busy
);

    localparam int unsigned HALF_W  = $clog2(TX_HALF) + 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned CNT_W   = $clog2(FSER_BITS);

    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(TX_HALF - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(FSER_BITS - 1);

    fser_state_t          state, state_n;
    logic [FSER_BITS-1:0] shift, shift_n;
    logic [CNT_W-1:0]     bitcnt, bitcnt_n;
    logic [HALF_W-1:0]    hcnt, hcnt_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic                 guard, guard_n;
    logic                 fclk_o_n, data_o_n;
    logic [7:0]           rx_data_n;
    logic                 rx_valid_n, rx_overrun_n;

    logic fclk_lvl, fclk_rise, fclk_fall;
    logic data_lvl, data_rise, data_fall;
    logic fclk_fall_eff;
    logic half_done;
    logic unused_filt;

    c1581_fser_filt u_filt_fclk (
        .clk    (clk),
        .res_n  (res_n),
        .ce     (ce),
        .pin    (fclk_i),
        .level  (fclk_lvl),
        .rise_c (fclk_rise),
        .fall_c (fclk_fall)
    );

    c1581_fser_filt u_filt_data (
        .clk    (clk),
        .res_n  (res_n),
        .ce     (ce),
        .pin    (data_i),
        .level  (data_lvl),
        .rise_c (data_rise),
        .fall_c (data_fall)
    );

    assign unused_filt = ^{fclk_lvl, data_rise, data_fall};

    // guard masks stale synchronizer edges for one ce after returning to IDLE.
    assign fclk_fall_eff = fclk_fall & ~guard;
    assign tx_ready      = ce & (state == IDLE) & ~fclk_fall_eff & ~guard;
    assign half_done     = (hcnt == HALF_LAST);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            shift      <= '0;
            bitcnt     <= '0;
            hcnt       <= '0;
            timer      <= '0;
            guard      <= 1'b1;
            fclk_o     <= 1'b1;
            data_o     <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (ce) begin
            state      <= state_n;
            shift      <= shift_n;
            bitcnt     <= bitcnt_n;
            hcnt       <= hcnt_n;
            timer      <= timer_n;
            guard      <= guard_n;
            fclk_o     <= fclk_o_n;
            data_o     <= data_o_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            rx_overrun <= rx_overrun_n;
        end
    end

    // Next state; a falling FCLK edge in IDLE beats a pending TX request.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (fclk_fall_eff) begin
                    state_n = RX_SHIFT;
                end else if (tx_valid && tx_ready) begin
                    state_n = TX_LOW;
                end
            end
            RX_SHIFT: begin
                if (fclk_rise && (bitcnt == BIT_LAST)) begin
                    state_n = IDLE;
                end else if (!fclk_rise && !fclk_fall && (timer == TIMER_LAST)) begin
                    state_n = IDLE;
                end
            end
            TX_LOW: begin
                if (half_done) begin
                    state_n = TX_HIGH;
                end
            end
            TX_HIGH: begin
                if (half_done) begin
                    state_n = (bitcnt == BIT_LAST) ? IDLE : TX_LOW;
                end
            end
        endcase
    end

    // Datapath and registered line drives.
    always_comb begin
        shift_n      = shift;
        bitcnt_n     = bitcnt;
        hcnt_n       = (&hcnt) ? hcnt : hcnt + HALF_W'(1);
        timer_n      = timer;
        guard_n      = (state != IDLE) && (state_n == IDLE);
        fclk_o_n     = fclk_o;
        data_o_n     = data_o;
        rx_data_n    = rx_data;
        rx_valid_n   = rx_valid;
        rx_overrun_n = rx_overrun;

        if (rx_valid && rx_ready) begin
            rx_valid_n   = 1'b0;
            rx_overrun_n = 1'b0;
        end

        unique case (state)
            IDLE: begin
                bitcnt_n = '0;
                hcnt_n   = '0;
                timer_n  = '0;
                if (state_n == TX_LOW) begin
                    shift_n  = tx_data;
                    fclk_o_n = 1'b0;
                    data_o_n = tx_data[FSER_BITS-1];
                end
            end
            RX_SHIFT: begin
                timer_n = (fclk_rise || fclk_fall) ? '0 : timer + TIMER_W'(1);
                if (fclk_rise) begin
                    shift_n  = {shift[FSER_BITS-2:0], data_lvl};
                    bitcnt_n = bitcnt + CNT_W'(1);
                    if (bitcnt == BIT_LAST) begin
                        rx_data_n  = {shift[FSER_BITS-2:0], data_lvl};
                        rx_valid_n = 1'b1;
                        if (rx_valid && !rx_ready) begin
                            rx_overrun_n = 1'b1;
                        end
                    end
                end
            end
            TX_LOW: begin
                if (half_done) begin
                    hcnt_n   = '0;
                    fclk_o_n = 1'b1;
                end
            end
            TX_HIGH: begin
                if (half_done) begin
                    hcnt_n = '0;
                    if (bitcnt == BIT_LAST) begin
                        data_o_n = 1'b1;
                    end else begin
                        bitcnt_n = bitcnt + CNT_W'(1);
                        shift_n  = {shift[FSER_BITS-2:0], 1'b0};
                        data_o_n = shift[FSER_BITS-2];
                        fclk_o_n = 1'b0;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_c1581_fser_host.sv
// Bench for c1581_fser_host: a drive model on the wired-AND lines plus
// queues of received bytes and transmitted bits checked against sent values.
module tb_c1581_fser_host;

    localparam int unsigned TX_HALF = 4;
    localparam int unsigned TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       res_n;
    logic       ce;
    logic       fclk_i, data_i, fclk_o, data_o;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overrun, busy;
    logic       drv_fclk, drv_data;
    logic       ce_rand;

    int n_checks = 0;
    int n_pass   = 0;
    int tx_acc   = 0;
    int tx_seen  = 0;

    bit         tx_bits[$];
    int         tx_lows[$];
    logic [7:0] rx_q[$];

    assign fclk_i = fclk_o & drv_fclk;
    assign data_i = data_o & drv_data;

    always #5 clk = ~clk;

    c1581_fser_host #(.TX_HALF(TX_HALF), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .ce         (ce),
        .fclk_i     (fclk_i),
        .data_i     (data_i),
        .fclk_o     (fclk_o),
        .data_o     (data_o),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (tx_valid && tx_ready) tx_acc <= tx_acc + 1;
    end

    // Drive side of the bus: record DATA at every host FCLK rise and the
    // number of enabled cycles FCLK was held low before it.
    initial begin : tx_mon
        logic prev;
        int   lowc;
        prev = 1'b1;
        lowc = 0;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                prev = 1'b1;
                lowc = 0;
            end else begin
                if (!fclk_o && ce) lowc++;
                if (fclk_o && !prev) begin
                    tx_bits.push_back(data_o);
                    tx_lows.push_back(lowc);
                    lowc = 0;
                end
                prev = fclk_o;
            end
        end
    end

    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (res_n && ce && rx_valid && rx_ready) rx_q.push_back(rx_data);
        end
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_valid && tx_acc != tx_seen) tx_valid = 1'b0;
        tx_seen = tx_acc;
        if (ce_rand) ce = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drive_bit(input logic b, input int half);
        drv_fclk = 1'b0;
        drv_data = b;
        repeat (half) tick();
        drv_fclk = 1'b1;
        repeat (half) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int half);
        for (int i = 7; i >= 0; i--) drive_bit(b[i], half);
        drv_data = 1'b1;
        repeat (8) tick();
    endtask

    // First FCLK fall coincides with a new TX request; the RX byte must win.
    task automatic send_collide(input logic [7:0] b, input logic [7:0] pend, input int half);
        drv_fclk = 1'b0;
        drv_data = b[7];
        repeat (3) tick();
        tx_data  = pend;
        tx_valid = 1'b1;
        chk("collide_tx_ready", tx_ready, 0);
        tick();
        chk("collide_fclk_o", fclk_o, 1);
        chk("collide_busy", busy, 1);
        repeat (half - 4) tick();
        drv_fclk = 1'b1;
        repeat (half) tick();
        for (int i = 6; i >= 0; i--) drive_bit(b[i], half);
        drv_data = 1'b1;
        repeat (8) tick();
    endtask

    task automatic tx_send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 400 && tx_valid; i++) tick();
        chk("tx_accept", tx_valid, 0);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && (busy || tx_valid); i++) tick();
        chk(tag, busy, 0);
        repeat (3) tick();
    endtask

    task automatic check_tx(input logic [7:0] exp, input int base, input string tag);
        logic [7:0] got;
        int bad;
        got = '0;
        bad = 0;
        chk({tag, "_nbits"}, tx_bits.size() - base, 8);
        if (tx_bits.size() >= base + 8) begin
            for (int i = 0; i < 8; i++) begin
                got = {got[6:0], tx_bits[base + i]};
                if (tx_lows[base + i] != TX_HALF) bad++;
            end
        end
        chk(tag, got, exp);
        chk({tag, "_lowlen"}, bad, 0);
    endtask

    task automatic check_rx(input logic [7:0] exp, input int base, input string tag);
        chk({tag, "_nbytes"}, rx_q.size() - base, 1);
        if (rx_q.size() > base) chk(tag, rx_q[base], exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         rb, tb_base, n;
        logic [7:0] b;
        int         half;

        res_n = 1'b0; ce = 1'b1; ce_rand = 1'b0;
        drv_fclk = 1'b1; drv_data = 1'b1;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fclk_o", fclk_o, 1);
        chk("rst_data_o", data_o, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        chk("rst_busy", busy, 0);
        res_n = 1'b1;
        repeat (4) tick();

        // RX of 0xA5 at 64 ce per bit
        rb = rx_q.size();
        send_byte(8'hA5, 32);
        check_rx(8'hA5, rb, "rx_a5");
        chk("rx_a5_overrun", rx_overrun, 0);
        chk("rx_a5_busy", busy, 0);
        chk("rx_a5_valid", rx_valid, 0);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        send_byte(8'h3C, 32);
        chk("ovr_first_valid", rx_valid, 1);
        chk("ovr_first_data", rx_data, 8'h3C);
        chk("ovr_first_flag", rx_overrun, 0);
        send_byte(8'hC3, 32);
        chk("ovr_second_valid", rx_valid, 1);
        chk("ovr_second_data", rx_data, 8'hC3);
        chk("ovr_second_flag", rx_overrun, 1);
        rx_ready = 1'b1;
        tick();
        chk("ovr_ack_valid", rx_valid, 0);
        chk("ovr_ack_flag", rx_overrun, 0);
        repeat (4) tick();

        // TX of 0x81: 8 bits of 2*TX_HALF ce
        tb_base = tx_bits.size();
        tx_send(8'h81);
        n = 0;
        for (int i = 0; i < 300 && busy; i++) begin
            n++;
            tick();
        end
        chk("tx81_busy_cycles", n, 8 * 2 * TX_HALF);
        chk("tx81_end_fclk_o", fclk_o, 1);
        chk("tx81_end_data_o", data_o, 1);
        repeat (2) tick();
        chk("tx81_ready_again", tx_ready, 1);
        check_tx(8'h81, tb_base, "tx81");

        // RX/TX collision
        rb = rx_q.size();
        tb_base = tx_bits.size();
        send_collide(8'h55, 8'hA7, 32);
        wait_idle("collide_idle");
        check_rx(8'h55, rb, "collide_rx");
        check_tx(8'hA7, tb_base, "collide_tx");

        // Partial byte then silence until timeout
        rb = rx_q.size();
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 16);
        chk("to_busy_partial", busy, 1);
        repeat (3960) tick();
        chk("to_busy_before", busy, 1);
        repeat (200) tick();
        chk("to_busy_after", busy, 0);
        chk("to_no_valid", rx_valid, 0);
        chk("to_no_byte", rx_q.size() - rb, 0);
        send_byte(8'h12, 32);
        check_rx(8'h12, rb, "to_rx12");

        // Randomized RX bytes and bit periods
        for (int k = 0; k < 6; k++) begin
            b    = 8'($urandom);
            half = $urandom_range(6, 40);
            rb   = rx_q.size();
            send_byte(b, half);
            check_rx(b, rb, "rx_rand");
            repeat ($urandom_range(0, 10)) tick();
        end

        // Randomized TX bytes with random ce gaps
        ce_rand = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            tb_base = tx_bits.size();
            tx_send(b);
            wait_idle("tx_rand_idle");
            check_tx(b, tb_base, "tx_rand");
        end
        ce_rand = 1'b0;
        ce = 1'b1;
        repeat (3) tick();

        // Reset in the middle of a transmitted byte
        tb_base = tx_bits.size();
        tx_send(8'hE1);
        for (int i = 0; i < 500 && (tx_bits.size() - tb_base) < 4; i++) tick();
        for (int i = 0; i < 20 && fclk_o; i++) tick();
        chk("mid_pre_fclk_o", fclk_o, 0);
        chk("mid_pre_data_o", data_o, 0);
        #2;
        res_n = 1'b0;
        #1;
        chk("mid_rst_fclk_o", fclk_o, 1);
        chk("mid_rst_data_o", data_o, 1);
        chk("mid_rst_busy", busy, 0);
        repeat (2) tick();
        res_n = 1'b1;
        repeat (3) tick();
        chk("mid_rel_tx_ready", tx_ready, 1);
        chk("mid_rel_rx_valid", rx_valid, 0);
        chk("mid_rel_busy", busy, 0);
        chk("mid_rel_overrun", rx_overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/c1581_fser_host.md
Name: c1581_fser_host

Overview:
- Computer-side fast-serial (burst) engine for the 1581 drive's fast-serial lines.
- Receives bytes the drive shifts out on FCLK/DATA while the drive's fast direction is output, and transmits host bytes with the host driving FCLK when the drive's direction is input.
- Sits between the drive's open-collector FCLK/DATA lines and the C64/C128-side bus arbiter and CPU glue.
- Presents valid/ready byte streams on both sides.

Parameters:
- TX_HALF, 32, clk-enabled cycles per FCLK half-period when transmitting (2 us at 16 MHz ce).
- TIMEOUT, 4096, ce cycles without an FCLK edge after which a partial RX byte is discarded.

Ports:
- clk  in  1  system clock
- res_n  in  1  reset: asynchronous, active-low
- ce  in  1  clock enable; all state advances only when ce=1
- fclk_i  in  1  wired-AND bus FCLK level (1 = released)
- data_i  in  1  wired-AND bus DATA level (1 = released)
- fclk_o  out  1  host FCLK drive (0 = pull low, 1 = release)
- data_o  out  1  host DATA drive (0 = pull low, 1 = release)
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  engine accepts tx_data this cycle
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid, held until accepted
- rx_ready  in  1  consumer accepts rx_data
- rx_overrun  out  1  sticky: a received byte was lost
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async, res_n=0):
  - fclk_o=1, data_o=1, tx_ready=0, rx_valid=0, rx_data=0, rx_overrun=0, busy=0.
  - State is IDLE; all counters are 0.
  - Releasing the lines is immediate, not clock-dependent.
- Input conditioning, per ce:
  - Two-stage synchronizer s1→s2 on fclk_i and data_i.
  - Filtered level updates only when s1==s2.
  - Edge detection uses the filtered FCLK against its previous value.
  - Latency from pin to filtered level is 2–3 ce cycles.
- States: IDLE, RX_SHIFT, TX_LOW, TX_HIGH.
- IDLE:
  - tx_ready=1 only in IDLE with no FCLK falling edge this cycle.
  - tx_valid & tx_ready: latch tx_data into the shift register, bitcnt=0, go to TX_LOW, and drive data_o=shift[7] and fclk_o=0 in the same transition.
  - Filtered FCLK falling edge with no TX accepted: go to RX_SHIFT, bitcnt=0, timer=0.
  - Simultaneous TX request and RX falling edge: RX wins; tx_ready is forced 0 that cycle.
- RX_SHIFT:
  - On each filtered FCLK rising edge, shift in filtered DATA MSB-first and increment bitcnt (3-bit).
  - Timer (13-bit) increments each ce and clears on any FCLK edge.
  - When the 8th bit is sampled: load rx_data, set rx_valid=1, return to IDLE.
  - If rx_valid is already 1 and not accepted in that cycle: overwrite rx_data with the new byte and set rx_overrun=1.
  - rx_overrun clears on the next rx_valid & rx_ready handshake.
  - Timer reaches TIMEOUT: discard the partial byte, return to IDLE, flag nothing.
- TX_LOW:
  - fclk_o=0 for TX_HALF ce cycles.
  - data_o holds the current bit, changing only on entry to TX_LOW.
  - Then go to TX_HIGH with fclk_o=1.
- TX_HIGH:
  - fclk_o=1 for TX_HALF ce cycles; the drive samples on the rising edge.
  - bitcnt<7: bitcnt++, shift left, go to TX_LOW with the new data_o.
  - bitcnt==7: data_o=1, fclk_o=1, go to IDLE.
  - Own FCLK edges are ignored while transmitting; RX detection is gated off in TX states.
  - Edges are also ignored for one extra ce cycle after returning to IDLE to absorb synchronizer lag.
- Handshake rules:
  - rx_data is stable while rx_valid=1.
  - rx_valid falls the cycle after an rx_valid & rx_ready handshake.
  - A new byte completing in the same cycle as a handshake is not an overrun.
  - tx_valid may be asserted at any time and is held by the source until tx_ready.
- Half-period counter is $clog2(TX_HALF)+1 bits and saturates; TX_HALF=1 is legal (minimum 2-cycle bit).
- ce=0 freezes everything, including timeout.
- Reset mid-byte aborts immediately with both lines released. No partial byte is reported.

Decomposition:
- Shared package c1581_pkg: state enum fser_state_t {IDLE, RX_SHIFT, TX_LOW, TX_HIGH}, plus a FSER_BITS=8 constant.
- One natural sub-module: c1581_fser_filt, the 2-FF synchronizer plus stability filter plus rise/fall edge outputs, instantiated for FCLK and DATA.
- The FSM and shift register stay in the top module.

Test Plan:
- RX: drive sends 0xA5 MSB-first, 4 us bits, rx_ready=1 → one rx_valid pulse with rx_data=0xA5, rx_overrun=0, busy back to 0.
- Overrun: two bytes 0x3C then 0xC3 with rx_ready=0 → rx_data=0xC3, rx_overrun=1. Then rx_ready=1 → rx_valid=0 and rx_overrun=0 next cycle.
- TX: tx_data=0x81, TX_HALF=4 → 8 FCLK low pulses of 4 ce each. DATA sampled at each fclk_o rise reads 1,0,0,0,0,0,0,1. Final state fclk_o=data_o=1, tx_ready=1 again after 64 ce.
- Collision: tx_valid rises in the same cycle the filtered FCLK falls → no TX starts, RX byte 0x55 received, then TX of the pending byte starts from IDLE.
- Timeout: 3 FCLK pulses then silence for TIMEOUT ce → IDLE with no rx_valid. A following full byte 0x12 is received correctly.
- Reset mid-TX: res_n=0 at bit 4 → fclk_o=data_o=1 asynchronously within the same cycle. After release: IDLE, tx_ready=1, no rx_valid.
